// File: rtl/fifo_rd_rr_sched.sv
// fifo_rd_rr_sched: round-robin burst read scheduler merging CHAN_NUM FIFOs onto one tagged valid/ready stream
module fifo_rd_rr_sched #(
  parameter int CHAN_NUM   = 4,
  parameter int CHAN_W     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic [CHAN_NUM-1:0]            chan_en_i,
  input  logic [CHAN_NUM-1:0]            empty_i,
  output logic [CHAN_NUM-1:0]            rd_en_o,
  input  logic [CHAN_NUM*DATA_WIDTH-1:0] rd_data_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CHAN_W-1:0]              out_chan,
  output logic                           busy_o
);
  typedef enum logic [1:0] {IDLE, READ, LATCH, HOLD} state_t;
  state_t state, state_n;
  logic [CHAN_W-1:0] grant, last_grant, pick, idx;
  logic [7:0] beat_cnt;
  logic [CHAN_NUM-1:0] req, gmask;
  logic [DATA_WIDTH-1:0] sel_data;
  logic burst_end;
  assign req = chan_en_i & ~empty_i;
  assign gmask = CHAN_NUM'(1) << grant;
  assign busy_o = state != IDLE;
  assign burst_end = (beat_cnt + 8'd1 == 8'(BURST_LEN)) | empty_i[grant] | ~chan_en_i[grant];
  // descending scan so the closest requester after last_grant is the final assignment
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = CHAN_NUM; i >= 1; i--) begin
      idx = CHAN_W'((int'(last_grant) + i) % CHAN_NUM);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHAN_NUM; k++)
      if (grant == CHAN_W'(k)) sel_data = rd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    state_n = state;
    rd_en_o = '0;
    case (state)
      IDLE:  state_n = |req ? READ : IDLE;
      READ: begin
        rd_en_o = gmask & ~empty_i;
        state_n = empty_i[grant] ? IDLE : LATCH;
      end
      LATCH: state_n = HOLD;
      HOLD:  state_n = !out_ready ? HOLD : burst_end ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= CHAN_W'(CHAN_NUM - 1);
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        grant <= pick;
        beat_cnt <= '0;
      end
      if (state == READ && empty_i[grant]) last_grant <= grant;
      if (state == LATCH) begin
        out_data <= sel_data;
        out_chan <= grant;
        out_valid <= 1'b1;
      end
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        beat_cnt <= beat_cnt + 8'd1;
        if (burst_end) last_grant <= grant;
      end
    end
endmodule

// File: doc/fifo_rd_rr_sched.md
Name: fifo_rd_rr_sched

Overview:
- Round-robin read scheduler for CHAN_NUM async FIFOs that share one consumer.
- All read-side controllers sit in the rd_clk domain.
- Selects a non-empty, enabled channel and drains up to BURST_LEN words from it by pulsing that FIFO's rd_en.
- Captures the 1-cycle-latency read data and presents it on a single valid/ready output stream tagged with the channel number.

Parameters:
- CHAN_NUM, 4, number of FIFO channels (2..16).
- CHAN_W, 2, channel index width; must equal clog2(CHAN_NUM).
- DATA_WIDTH, 32, FIFO data word width.
- BURST_LEN, 4, maximum words drained per grant (1..255).

Ports:
- rd_clk  input  1  scheduler clock (FIFO read clock).
- rd_rst  input  1  asynchronous active-high reset.
- chan_en_i  input  CHAN_NUM  per-channel enable; 0 masks the channel from arbitration.
- empty_i  input  CHAN_NUM  per-FIFO empty flag.
- rd_en_o  output  CHAN_NUM  per-FIFO read enable, one-hot or zero.
- rd_data_i  input  CHAN_NUM*DATA_WIDTH  FIFO read data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after rd_en.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accept.
- out_data  output  DATA_WIDTH  output word.
- out_chan  output  CHAN_W  source channel of out_data.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, rd_clk. rd_rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, last_grant=CHAN_NUM-1 (so channel 0 wins first), beat_cnt=0.
  - out_valid=0, out_data=0, out_chan=0, busy_o=0.
  - rd_en_o=0 immediately on rd_rst assertion.
- Request vector: req = chan_en_i & ~empty_i.
- FSM states: IDLE, READ, LATCH, HOLD.
- IDLE:
  - If req != 0, register grant = first set req bit, searching from (last_grant+1) mod CHAN_NUM upward with wrap.
  - Set beat_cnt=0 and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - rd_en_o = onehot(grant) & ~empty_i, combinational from registered state. It is high for exactly this one cycle.
  - If empty_i[grant]=1: no read; last_grant<=grant; go to IDLE.
  - Otherwise go to LATCH.
- LATCH:
  - rd_data_i slice for grant is valid in this cycle.
  - On the clock edge: out_data<=slice, out_chan<=grant, out_valid<=1; go to HOLD.
- HOLD:
  - out_valid, out_data and out_chan stay stable until out_ready=1.
  - On a cycle with out_ready=1: out_valid<=0 and beat_cnt<=beat_cnt+1 (8-bit).
  - If beat_cnt+1==BURST_LEN, or empty_i[grant]=1, or chan_en_i[grant]=0: last_grant<=grant and go to IDLE.
  - Otherwise go to READ on the same grant.
- Timing:
  - Latency from rd_en_o to out_valid is 2 cycles.
  - Sustained throughput with out_ready held high is 1 word per 3 cycles.
  - IDLE costs 1 extra cycle per grant.
- Fairness: after a burst, the granted channel has the lowest priority in the next arbitration. A channel that stays requesting is served within CHAN_NUM-1 intervening grants.
- Mid-burst disable: clearing chan_en_i[grant] never drops a word already read. That word is still delivered, then the burst ends.
- FIFO goes empty mid-burst: the burst ends early and no rd_en is issued to an empty FIFO.
- Reset mid-operation: any word held in the output stage is discarded. No rd_en pulse may appear in the cycle after rd_rst deasserts; the FSM restarts from IDLE.
- Single-reader rule: this block is the only reader of each FIFO. empty_i[grant] can only rise through this block's own reads.

Test Plan:
1. Round-robin order: CHAN_NUM=4, BURST_LEN=4, all enabled, ch0..ch3 each hold 8 words -> grants ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3, each burst 4 words. out_chan sequence matches, and out_data equals each FIFO's contents in order.
2. Short FIFO: only ch2 non-empty with 2 words (0xA1, 0xA2) -> exactly 2 rd_en_o[2] pulses, outputs 0xA1 then 0xA2 with out_chan=2, return to IDLE, busy_o=0, no rd_en to an empty FIFO.
3. Backpressure: out_ready=0 for 10 cycles during HOLD -> out_valid, out_data and out_chan stay constant, and no rd_en_o pulses. On out_ready=1 the word is accepted once and the next READ follows.
4. Mask: chan_en_i=4'b1011 with all FIFOs non-empty -> ch2 is never granted. Clearing chan_en_i[0] mid-burst -> the current word is still delivered, then the grant moves to ch1.
5. Reset mid-burst: assert rd_rst asynchronously during HOLD -> out_valid=0 and rd_en_o=0 without waiting for a clock edge. After release, the first grant is ch0.
6. Fairness: ch0 and ch3 continuously non-empty, BURST_LEN=1 -> grants alternate 0,3,0,3 with no repeats.
